// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator
// Consumes the registered sum/cout of an upstream ripple or pipelined adder.
// A valid delay line realigns the issue-side valid with the adder latency;
// a small IDLE/RUN/DONE FSM accumulates len results of {cout,sum} into a
// wide accumulator, pulses done for one cycle and keeps a sticky overflow.
// Optional build macro: ACC_SATURATE_EN (saturate instead of wrap on overflow).
module adder_result_accumulator #(
    parameter int BW    = 32,
    parameter int LAT   = 1,
    parameter int ACC_W = 40
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    input  logic             start,
    input  logic [15:0]      len,
    input  logic [BW-1:0]    sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc,
    output logic [15:0]      count,
    output logic             ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [15:0]      count_reg, count_next;
    logic [15:0]      len_reg, len_next;
    logic             ovf_reg, ovf_next;
    logic [LAT:1]     vpipe_reg;

    logic             res_valid;
    logic [ACC_W-1:0] addend;
    logic [ACC_W:0]   acc_sum;

    assign res_valid = vpipe_reg[LAT];
    // Unsigned {cout,sum}, zero-extended to the accumulator width.
    assign addend    = ACC_W'({cout, sum});
    // One extra bit so the carry out of the accumulator marks overflow.
    assign acc_sum   = {1'b0, acc_reg} + {1'b0, addend};

    // Valid delay line: res_valid lines up with the adder's registered output.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vpipe_reg <= '0;
        end else begin
            for (int k = LAT; k >= 2; k--) begin
                vpipe_reg[k] <= vpipe_reg[k-1];
            end
            vpipe_reg[1] <= in_valid;
        end
    end

    // Next-state and accumulate logic.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        len_next   = len_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            ST_IDLE: begin
                // Results arriving while idle are deliberately ignored.
                if (start) begin
                    acc_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                    len_next   = len;
                    state_next = (len == 16'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (res_valid) begin
                    count_next = count_reg + 16'd1;
`ifdef ACC_SATURATE_EN
                    // Once saturated, acc stays pinned at full scale for the run.
                    if (ovf_reg) begin
                        acc_next = acc_reg;
                    end else if (acc_sum[ACC_W]) begin
                        acc_next = '1;
                        ovf_next = 1'b1;
                    end else begin
                        acc_next = acc_sum[ACC_W-1:0];
                    end
`else
                    acc_next = acc_sum[ACC_W-1:0];
                    if (acc_sum[ACC_W]) begin
                        ovf_next = 1'b1;
                    end
`endif
                    if (count_reg == len_reg - 16'd1) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Single-cycle completion; start and results are dropped here.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
            len_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            len_reg   <= len_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign busy  = (state_reg != ST_IDLE);
    assign done  = (state_reg == ST_DONE);
    assign acc   = acc_reg;
    assign count = count_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Testbench for adder_result_accumulator: one LAT=1 and one LAT=2 instance.
// The bench models the adder as a LAT-deep delay of {cout,sum}; completed
// runs are checked by a done-pulse scoreboard, and accumulate timing of the
// LAT=2 instance by a second queue of expected visibility cycles.
module tb_adder_result_accumulator;

    typedef struct packed {
        logic [39:0] acc;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

`ifdef ACC_SATURATE_EN
    localparam logic [39:0] OVF_ACC = 40'hFF_FFFF_FFFF;
`else
    localparam logic [39:0] OVF_ACC = 40'h01_FFFF_FF7F;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic        iv1 = 1'b0, start1 = 1'b0;
    logic [15:0] len1 = '0;
    logic [32:0] d1 = '0, d1_q = '0;
    logic        busy1, done1, ovf1;
    logic [39:0] acc1;
    logic [15:0] count1;

    logic        iv2 = 1'b0, start2 = 1'b0;
    logic [15:0] len2 = '0;
    logic [32:0] d2 = '0, d2_a = '0, d2_b = '0;
    logic        busy2, done2, ovf2;
    logic [39:0] acc2;
    logic [15:0] count2;
    logic [15:0] prev_count2 = '0;

    exp_t q1[$];
    exp_t q2[$];
    int   tq2[$];
    exp_t e;
    int   t;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Adder model: registered result appears LAT cycles after issue.
    always @(posedge CLK) begin
        d1_q <= d1;
        d2_a <= d2;
        d2_b <= d2_a;
    end

    adder_result_accumulator #(.BW(32), .LAT(1), .ACC_W(40)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .in_valid(iv1), .start(start1), .len(len1),
        .sum(d1_q[31:0]), .cout(d1_q[32]),
        .busy(busy1), .done(done1), .acc(acc1), .count(count1), .ovf(ovf1)
    );

    adder_result_accumulator #(.BW(32), .LAT(2), .ACC_W(40)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .in_valid(iv2), .start(start2), .len(len2),
        .sum(d2_b[31:0]), .cout(d2_b[32]),
        .busy(busy2), .done(done2), .acc(acc2), .count(count2), .ovf(ovf2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and on every
    // accumulate of the LAT=2 instance.
    always @(negedge CLK) begin
        if (done1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL dut1 unexpected done: got done=1, required none");
            end else begin
                e = q1.pop_front();
                $display("[TB] dut1 run done acc=0x%0h count=%0d ovf=%0d", acc1, count1, ovf1);
                check("dut1 acc", 64'(acc1), 64'(e.acc));
                check("dut1 count", 64'(count1), 64'(e.cnt));
                check("dut1 ovf", 64'(ovf1), 64'(e.ovf));
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL dut2 unexpected done: got done=1, required none");
            end else begin
                e = q2.pop_front();
                $display("[TB] dut2 run done acc=0x%0h count=%0d ovf=%0d", acc2, count2, ovf2);
                check("dut2 acc", 64'(acc2), 64'(e.acc));
                check("dut2 count", 64'(count2), 64'(e.cnt));
                check("dut2 ovf", 64'(ovf2), 64'(e.ovf));
            end
        end
        if (count2 != prev_count2 && count2 != 16'd0) begin
            if (tq2.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL dut2 unexpected accumulate: got count=%0d, required none", count2);
            end else begin
                t = tq2.pop_front();
                check("dut2 accumulate cycle", 64'(cyc), 64'(t));
            end
        end
        prev_count2 = count2;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        start1 = 1'b0; start2 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    endtask

    task automatic issue1(input logic [32:0] d);
        iv1 = 1'b1; d1 = d;
        tick();
    endtask

    // LAT=2: result visible in acc/count at cycle issue+3.
    task automatic issue2(input logic [32:0] d);
        iv2 = 1'b1; d2 = d;
        tq2.push_back(cyc + 3);
        tick();
    endtask

    task automatic wait_idle(input int which);
        for (int i = 0; i < 400; i++) begin
            if ((which == 1) ? !busy1 : !busy2) return;
            tick();
        end
        tests++; fails++;
        $display("[TB] FAIL dut%0d timeout: got busy=1, required busy=0", which);
    endtask

    task automatic check_zero2(input string tag);
        check({tag, " busy"}, 64'(busy2), 64'd0);
        check({tag, " done"}, 64'(done2), 64'd0);
        check({tag, " acc"}, 64'(acc2), 64'd0);
        check({tag, " count"}, 64'(count2), 64'd0);
        check({tag, " ovf"}, 64'(ovf2), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("reset dut1 busy", 64'(busy1), 64'd0);
        check("reset dut1 done", 64'(done1), 64'd0);
        check("reset dut1 acc", 64'(acc1), 64'd0);
        check("reset dut1 count", 64'(count1), 64'd0);
        check("reset dut1 ovf", 64'(ovf1), 64'd0);
        check_zero2("reset dut2");

        // Basic run: 1+2+3
        q1.push_back('{acc: 40'd6, cnt: 16'd3, ovf: 1'b0});
        start1 = 1'b1; len1 = 16'd3;
        tick();
        check("basic busy after start", 64'(busy1), 64'd1);
        issue1(33'd1);
        issue1(33'd2);
        issue1(33'd3);
        tick();
        check("basic done pulse", 64'(done1), 64'd1);
        tick();
        check("basic done one cycle", 64'(done1), 64'd0);
        check("basic busy cleared", 64'(busy1), 64'd0);

        // Result while idle is ignored
        issue1(33'd5);
        tick(); tick();
        check("idle result acc held", 64'(acc1), 64'd6);
        check("idle result count held", 64'(count1), 64'd3);

        // Start during RUN does not restart
        q1.push_back('{acc: 40'd8, cnt: 16'd2, ovf: 1'b0});
        start1 = 1'b1; len1 = 16'd2;
        tick();
        start1 = 1'b1; len1 = 16'd5;
        issue1(33'd4);
        issue1(33'd4);
        wait_idle(1);

        // Zero length
        q1.push_back('{acc: 40'd0, cnt: 16'd0, ovf: 1'b0});
        start1 = 1'b1; len1 = 16'd0;
        tick();
        check("len0 done", 64'(done1), 64'd1);
        check("len0 acc", 64'(acc1), 64'd0);
        tick();
        check("len0 busy cleared", 64'(busy1), 64'd0);

        // Overflow: 129 x 0x1_FFFFFFFF
        q1.push_back('{acc: OVF_ACC, cnt: 16'd129, ovf: 1'b1});
        start1 = 1'b1; len1 = 16'd129;
        tick();
        for (int i = 0; i < 128; i++) issue1(33'h1_FFFF_FFFF);
        tick();
        check("ovf128 acc", 64'(acc1), 64'hFF_FFFF_FF80);
        check("ovf128 count", 64'(count1), 64'd128);
        check("ovf128 ovf", 64'(ovf1), 64'd0);
        issue1(33'h1_FFFF_FFFF);
        wait_idle(1);
        tick();
        check("ovf hold acc", 64'(acc1), 64'(OVF_ACC));
        check("ovf hold flag", 64'(ovf1), 64'd1);

        // Pipelined latency with gaps: 1,0,1,1,0,1
        q2.push_back('{acc: 40'hA0, cnt: 16'd4, ovf: 1'b0});
        start2 = 1'b1; len2 = 16'd4;
        tick();
        issue2(33'h10);
        tick();
        issue2(33'h20);
        issue2(33'h30);
        tick();
        issue2(33'h40);
        wait_idle(2);

        // Reset mid-run with an in-flight result
        start2 = 1'b1; len2 = 16'd4;
        tick();
        issue2(33'h1);
        issue2(33'h2);
        tick(); tick();
        check("midrun count", 64'(count2), 64'd2);
        check("midrun acc", 64'(acc2), 64'd3);
        iv2 = 1'b1; d2 = 33'h100;
        tick();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check_zero2("midrun reset dut2");
        q2.push_back('{acc: 40'd7, cnt: 16'd1, ovf: 1'b0});
        start2 = 1'b1; len2 = 16'd1;
        tick();
        issue2(33'd7);
        wait_idle(2);
        tick();
        check("after reset acc", 64'(acc2), 64'd7);

        repeat (4) tick();
        check("scoreboard drained", 64'(q1.size() + q2.size() + tq2.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
